regfile_param: RTL and testbench
================================

// Module: regfile_param
//
// PURPOSE
//   Parametrised MIPS-style general register file; successor to the fixed 32x32 two-read-port file.
//   Configurable width, depth, read-port count and debug tap set, with same-cycle write-to-read bypass
//   and a sequenced soft-clear engine (one register per cycle) with a busy/drop handshake.
//   Sits in the decode stage; taps feed the board display / debug logic.
//
// PARAMETERS
//   DW        32        data width in bits
//   AW        5         register index width; DEPTH = 2**AW
//   NREAD     2         number of independent read ports
//   ZERO_REG  1         1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//   NTAP      4         number of debug tap outputs
//   TAP_IDX   {5'd31,5'd18,5'd19,5'd16}  packed NTAP*AW tap indices, tap k = TAP_IDX[k*AW +: AW] (default s0,s3,s2,ra)
//
// PORTS
//   clk      in   1          clock; all state updates on rising edge
//   reset    in   1          synchronous, active-low reset
//   clr      in   1          soft-clear request, sampled only when busy==0
//   busy     out  1          soft-clear sweep in progress
//   WE       in   1          write enable
//   RW_no    in   AW         write index
//   Din      in   DW         write data
//   wr_drop  out  1          registered: a WE in the previous cycle was discarded because busy==1
//   R_no     in   NREAD*AW   packed read indices, port i = R_no[i*AW +: AW]
//   R_val    out  NREAD*DW   packed read data, combinational
//   tap_val  out  NTAP*DW    packed stored values of TAP_IDX registers, combinational, no bypass
//
// BEHAVIOUR
//   - Reset (reset==0 at rising edge): all DEPTH registers <= 0, FSM -> IDLE, busy=0, wr_drop=0. Overrides clr/WE.
//     Reset mid-sweep aborts the sweep; all registers still end at 0.
//   - Write (IDLE): WE==1 at rising edge -> reg[RW_no] <= Din, except RW_no==0 with ZERO_REG=1 (no effect).
//   - Read: R_val[i] = 0 if ZERO_REG && R_no[i]==0; else Din if WE && !busy && R_no[i]==RW_no
//     (bypass, equivalent to write-before-read in the same cycle); else reg[R_no[i]].
//     All ports independent; any number may alias the same index.
//   - Taps: tap_val[k] = reg[TAP_IDX[k]] (stored value; a same-cycle write appears the following cycle).
//   - FSM states IDLE, SWEEP; internal pointer ptr (AW bits).
//     IDLE: clr==1 -> SWEEP, ptr <= START (START = 1 if ZERO_REG else 0). WE in the same cycle as clr is
//       performed (busy still 0), then overwritten by the sweep when ptr reaches it.
//     SWEEP: each edge reg[ptr] <= 0, ptr <= ptr+1; after clearing index DEPTH-1 -> IDLE.
//       busy==1 exactly DEPTH-START cycles (31 by default), starting the cycle after clr was sampled.
//     clr while busy is ignored (no restart, no extension).
//   - WE while busy: write discarded, no bypass; wr_drop==1 the next cycle, else 0. Reads during sweep return
//     the stored value (0 for already-cleared indices, old value for not-yet-cleared).
//   - No arithmetic beyond ptr increment; ptr never wraps past DEPTH-1 (FSM exits first).
//
// TESTING
//   1. Reset low 1 cycle, then read all 32 indices on both ports -> all 0; busy=0, wr_drop=0, taps 0.
//   2. WE=1 RW_no=8 Din=32'hDEADBEEF, R_no[0]=8 same cycle -> R_val[0]=DEADBEEF (bypass); next cycle WE=0 -> still DEADBEEF;
//      tap for index 16 unchanged.
//   3. WE=1 RW_no=0 Din=32'h1234 (ZERO_REG=1) -> R_val for index 0 is 0 that cycle and after; with ZERO_REG=0 build -> 1234.
//   4. Load regs 1..31 with value=index, pulse clr -> busy high 31 cycles; mid-sweep (cycle 10) reg 5 reads 0, reg 20 reads 20;
//      after busy falls all read 0.
//   5. WE=1 RW_no=3 Din=7 during busy -> wr_drop=1 next cycle, reg 3 stays 0 after sweep, no bypass seen on R_val.
//   6. Reset low at sweep cycle 5 -> next cycle busy=0, all regs 0; a later WE RW_no=31 Din=9 -> tap ra=9 one cycle later.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised general register file for the decode stage.
//   DEPTH = 2**AW registers of DW bits, NREAD combinational read ports with
//   same-cycle write-to-read bypass, NTAP debug taps (stored values only), and
//   a soft-clear engine that zeroes one register per cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low reset (clears every register)
//   clr      soft-clear request, sampled only while not busy
//   busy     soft-clear sweep in progress
//   WE       write enable
//   RW_no    write index
//   Din      write data
//   wr_drop  registered flag: a write in the previous cycle was dropped (busy)
//   R_no     packed read indices, port i = R_no[i*AW +: AW]
//   R_val    packed read data, port i = R_val[i*DW +: DW]
//   tap_val  packed stored values of the TAP_IDX registers
module regfile_param #(
    parameter int unsigned            DW       = 32,
    parameter int unsigned            AW       = 5,
    parameter int unsigned            NREAD    = 2,
    parameter int unsigned            ZERO_REG = 1,
    parameter int unsigned            NTAP     = 4,
    parameter logic [NTAP*AW-1:0]     TAP_IDX  = {5'd31, 5'd18, 5'd19, 5'd16}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  WE,
    input  logic [AW-1:0]         RW_no,
    input  logic [DW-1:0]         Din,
    output logic                  wr_drop,
    input  logic [NREAD*AW-1:0]   R_no,
    output logic [NREAD*DW-1:0]   R_val,
    output logic [NTAP*DW-1:0]    tap_val
);

    localparam int unsigned   DEPTH = 2 ** AW;
    // First index swept; register 0 is skipped when it is hard-wired to zero.
    localparam logic [AW-1:0] START = (ZERO_REG != 0) ? AW'(1) : '0;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;
    logic [DW-1:0] regs [DEPTH];
    logic          wr_ok;
    logic          byp_en;

    assign busy   = (state == SWEEP);
    // Writes to register 0 are suppressed when it is hard-wired to zero.
    assign wr_ok  = WE && !((ZERO_REG != 0) && (RW_no == '0));
    assign byp_en = WE && !busy;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx = SWEEP;
                    ptr_nx   = START;
                end
            end
            SWEEP: begin
                if (ptr == '1) begin
                    state_nx = IDLE;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            wr_drop <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            wr_drop <= WE && busy;
            if (busy) begin
                regs[ptr] <= '0;
            end else if (wr_ok) begin
                // A write in the same cycle as clr still lands; the sweep
                // overwrites it later when ptr reaches that index.
                regs[RW_no] <= Din;
            end
        end
    end

    always_comb begin
        R_val = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if ((ZERO_REG != 0) && (R_no[i*AW +: AW] == '0)) begin
                R_val[i*DW +: DW] = '0;
            end else if (byp_en && (R_no[i*AW +: AW] == RW_no)) begin
                R_val[i*DW +: DW] = Din;
            end else begin
                R_val[i*DW +: DW] = regs[R_no[i*AW +: AW]];
            end
        end
    end

    always_comb begin
        tap_val = '0;
        for (int unsigned k = 0; k < NTAP; k++) begin
            tap_val[k*DW +: DW] = regs[TAP_IDX[k*AW +: AW]];
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed steps plus a randomized phase,
// compared against a behavioural array model of the register file.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        busy;
    logic        WE;
    logic [4:0]  RW_no;
    logic [31:0] Din;
    logic        wr_drop;
    logic [9:0]  R_no;
    logic [63:0] R_val;
    logic [127:0] tap_val;

    // Second instance with an ordinary register 0.
    logic        clr0 = 1'b0;
    logic        busy0;
    logic        we0 = 1'b0;
    logic [4:0]  rw0 = '0;
    logic [31:0] din0 = '0;
    logic        wr_drop0;
    logic [9:0]  rno0 = '0;
    logic [63:0] rval0;
    logic [127:0] tap0;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] mem [32];
    bit          m_busy;
    int          m_ptr;
    bit          m_drop;
    int          tapi [4] = '{16, 19, 18, 31};

    always #5 clk = ~clk;

    regfile_param u_dut (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy), .WE(WE),
        .RW_no(RW_no), .Din(Din), .wr_drop(wr_drop), .R_no(R_no),
        .R_val(R_val), .tap_val(tap_val)
    );

    regfile_param #(.ZERO_REG(0)) u_dut0 (
        .clk(clk), .reset(reset), .clr(clr0), .busy(busy0), .WE(we0),
        .RW_no(rw0), .Din(din0), .wr_drop(wr_drop0), .R_no(rno0),
        .R_val(rval0), .tap_val(tap0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input int idx);
        if (idx == 0) return 32'h0;
        if (WE && !m_busy && idx == int'(RW_no)) return Din;
        return mem[idx];
    endfunction

    // One rising edge; the model applies the same rules to the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            foreach (mem[i]) mem[i] = '0;
            m_busy = 0;
            m_drop = 0;
        end else begin
            m_drop = WE && m_busy;
            if (m_busy) begin
                mem[m_ptr] = '0;
                if (m_ptr == 31) m_busy = 0;
                else m_ptr++;
            end else begin
                if (WE && RW_no != 0) mem[RW_no] = Din;
                if (clr) begin
                    m_busy = 1;
                    m_ptr  = 1;
                end
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "/busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "/wr_drop"}, 32'(wr_drop), 32'(m_drop));
        for (int p = 0; p < 2; p++)
            chk($sformatf("%s/R_val%0d[%0d]", tag, p, R_no[p*5 +: 5]),
                R_val[p*32 +: 32], exp_read(int'(R_no[p*5 +: 5])));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s/tap%0d", tag, k), tap_val[k*32 +: 32], mem[tapi[k]]);
    endtask

    task automatic rand_reads();
        R_no = 10'($urandom);
    endtask

    task automatic load_all();
        for (int i = 1; i < 32; i++) begin
            WE = 1'b1; RW_no = 5'(i); Din = 32'(i);
            rand_reads();
            check_all("load");
            tick();
        end
        WE = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            R_no = {5'(31 - i), 5'(i)};
            check_all(tag);
            chk({tag, "/zero0"}, R_val[31:0], 32'h0);
        end
    endtask

    initial begin
        int busy_cnt;
        foreach (mem[i]) mem[i] = '0;
        m_busy = 0; m_drop = 0; m_ptr = 0;
        reset = 1'b0; clr = 1'b0; WE = 1'b0; RW_no = '0; Din = '0; R_no = '0;

        // 1: reset, everything reads zero
        tick();
        reset = 1'b1;
        read_all_zero("reset");

        // 2: bypass then stored value
        WE = 1'b1; RW_no = 5'd8; Din = 32'hDEADBEEF; R_no = {5'd16, 5'd8};
        check_all("byp");
        chk("byp_r8", R_val[31:0], 32'hDEADBEEF);
        tick();
        WE = 1'b0;
        check_all("byp_after");
        chk("stored_r8", R_val[31:0], 32'hDEADBEEF);
        chk("tap_s0_unchanged", tap_val[31:0], 32'h0);

        // 3: register 0 hard-wired vs ordinary
        WE = 1'b1; RW_no = 5'd0; Din = 32'h1234; R_no = {5'd0, 5'd0};
        we0 = 1'b1; rw0 = 5'd0; din0 = 32'h1234; rno0 = {5'd0, 5'd0};
        check_all("r0_wr");
        chk("r0_zr1_byp", R_val[31:0], 32'h0);
        chk("r0_zr0_byp", rval0[31:0], 32'h1234);
        tick();
        WE = 1'b0; we0 = 1'b0;
        check_all("r0_after");
        chk("r0_zr1_stored", R_val[63:32], 32'h0);
        chk("r0_zr0_stored", rval0[63:32], 32'h1234);

        // 4: load 1..31, sweep
        load_all();
        clr = 1'b1; rand_reads();
        check_all("clr");
        tick();
        clr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) R_no = {5'd20, 5'd5};
            else rand_reads();
            check_all("sweep");
            if (c == 10) begin
                chk("mid_r5", R_val[31:0], 32'h0);
                chk("mid_r20", R_val[63:32], 32'd20);
            end
            if (busy) busy_cnt++;
            tick();
        end
        chk("busy_len", 32'(busy_cnt), 32'd31);
        read_all_zero("post_sweep");

        // 5: write during busy is dropped
        load_all();
        clr = 1'b1;
        check_all("clr2");
        tick();
        clr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 2) begin
                WE = 1'b1; RW_no = 5'd3; Din = 32'd7; R_no = {5'd3, 5'd3};
            end else begin
                WE = 1'b0; rand_reads();
            end
            check_all("sweep2");
            if (c == 2) chk("no_byp_r3", R_val[31:0], 32'd3);
            if (c == 3) chk("wr_drop_set", 32'(wr_drop), 32'd1);
            if (c == 4) chk("wr_drop_clr", 32'(wr_drop), 32'd0);
            tick();
        end
        WE = 1'b0;
        R_no = {5'd3, 5'd3};
        check_all("r3_after");
        chk("r3_cleared", R_val[31:0], 32'h0);

        // 6: reset mid-sweep
        load_all();
        clr = 1'b1;
        check_all("clr3");
        tick();
        clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) reset = 1'b0;
            rand_reads();
            check_all("sweep3");
            tick();
        end
        reset = 1'b1;
        check_all("abort");
        chk("abort_busy", 32'(busy), 32'd0);
        read_all_zero("abort");
        WE = 1'b1; RW_no = 5'd31; Din = 32'd9;
        check_all("ra_wr");
        chk("tap_ra_pre", tap_val[127:96], 32'h0);
        tick();
        WE = 1'b0;
        check_all("ra_after");
        chk("tap_ra", tap_val[127:96], 32'd9);

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            WE    = 1'($urandom);
            RW_no = 5'($urandom);
            Din   = $urandom;
            clr   = ($urandom_range(0, 29) == 0);
            R_no  = 10'($urandom);
            if ($urandom_range(0, 1) == 1) R_no[9:5] = RW_no;
            check_all("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
